uart_rx_fsm: RTL and testbench

Receive-side controller for the UART_RX path. It oversamples the serial line `rx_in` at `prescale` clocks per bit and majority-votes three mid-bit samples. It drives the deserializer's `sampled_bit`/`deser_en` inputs with one enable pulse per data bit. It also checks start-glitch, parity and stop bit, then flags a completed frame with a single-cycle `data_valid` alongside the deserializer's `p_data`.

---
 rtl/uart_rx_fsm_if.sv | 25 ++
 rtl/uart_rx_fsm.sv | 116 +++++++++++
 tb/tb_uart_rx_fsm.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fsm_if.sv
// Serial-line and deserializer-control bundle for the UART receive controller.
interface uart_rx_fsm_if #(
   parameter int PRESCALE_W = 6
);
   logic                  rx_in;
   logic [PRESCALE_W-1:0] prescale;
   logic                  par_en;
   logic                  par_typ;
   logic                  sampled_bit;
   logic                  deser_en;
   logic                  data_valid;
   logic                  par_err;
   logic                  stp_err;
   logic                  busy;

   modport master (
      output rx_in, prescale, par_en, par_typ,
      input  sampled_bit, deser_en, data_valid, par_err, stp_err, busy
   );

   modport slave (
      input  rx_in, prescale, par_en, par_typ,
      output sampled_bit, deser_en, data_valid, par_err, stp_err, busy
   );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART receive controller: oversampled 3-point majority vote per bit, start-glitch/parity/stop checks.
// deser_en lands at edge P/2+2 of each data bit; data_valid follows the last stop edge by one cycle.
module uart_rx_fsm #(
   parameter int DATA_W     = 8,
   parameter int PRESCALE_W = 6
) (
   input logic          clk,
   input logic          rst,
   uart_rx_fsm_if.slave bus
);
   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                state_q, state_d;
   logic [PRESCALE_W-1:0] p_q, p_dec, half;
   logic [PRESCALE_W-1:0] edge_q, edge_d;
   logic [BW-1:0]         bit_q;
   logic                  par_en_q, par_typ_q;
   logic                  s0_q, s1_q, sampled_q;
   logic                  par_acc_q, par_err_q, stp_err_q, data_valid_q;
   logic                  start_det, e_s0, e_s1, e_vote, e_mid, e_last, vote;

   // Anything other than 16 or 32 falls back to 8x oversampling.
   always_comb begin
      p_dec = PRESCALE_W'(8);
      if (bus.prescale == PRESCALE_W'(16))
         p_dec = PRESCALE_W'(16);
      else if (bus.prescale == PRESCALE_W'(32))
         p_dec = PRESCALE_W'(32);
   end

   assign half      = p_q >> 1;
   assign e_s0      = (edge_q == half - PRESCALE_W'(1));
   assign e_s1      = (edge_q == half);
   assign e_vote    = (edge_q == half + PRESCALE_W'(1));
   assign e_mid     = (edge_q == half + PRESCALE_W'(2));
   assign e_last    = (edge_q == p_q - PRESCALE_W'(1));
   assign start_det = (state_q == IDLE) && !bus.rx_in;
   assign vote      = (s0_q & s1_q) | (s0_q & bus.rx_in) | (s1_q & bus.rx_in);

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!bus.rx_in) state_d = START;
         START:   if (e_mid && sampled_q) state_d = IDLE;
                  else if (e_last)        state_d = DATA;
         DATA:    if (e_last && bit_q == BW'(DATA_W - 1))
                     state_d = par_en_q ? PARITY : STOP;
         PARITY:  if (e_last) state_d = STOP;
         STOP:    if (e_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The detect cycle is edge 0 of the start bit, so the first START cycle is edge 1.
   always_comb begin
      edge_d = '0;
      if (state_q == IDLE)
         edge_d = start_det ? PRESCALE_W'(1) : '0;
      else if (state_d != IDLE && !e_last)
         edge_d = edge_q + PRESCALE_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p_q          <= PRESCALE_W'(8);
         edge_q       <= '0;
         bit_q        <= '0;
         par_en_q     <= 1'b0;
         par_typ_q    <= 1'b0;
         s0_q         <= 1'b0;
         s1_q         <= 1'b0;
         sampled_q    <= 1'b0;
         par_acc_q    <= 1'b0;
         par_err_q    <= 1'b0;
         stp_err_q    <= 1'b0;
         data_valid_q <= 1'b0;
      end else begin
         edge_q       <= edge_d;
         data_valid_q <= (state_q == STOP) && e_last && !par_err_q && !stp_err_q;
         if (start_det) begin
            p_q       <= p_dec;
            par_en_q  <= bus.par_en;
            par_typ_q <= bus.par_typ;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
            bit_q     <= '0;
            par_acc_q <= 1'b0;
         end
         if (state_q != IDLE) begin
            if (e_s0)   s0_q      <= bus.rx_in;
            if (e_s1)   s1_q      <= bus.rx_in;
            if (e_vote) sampled_q <= vote;
         end
         if (state_q == DATA && e_mid)  par_acc_q <= par_acc_q ^ sampled_q;
         if (state_q == DATA && e_last) bit_q     <= bit_q + BW'(1);
         if (state_q == PARITY && e_mid) par_err_q <= sampled_q != (par_acc_q ^ par_typ_q);
         if (state_q == STOP && e_mid)   stp_err_q <= !sampled_q;
      end
   end

   always_comb begin
      bus.sampled_bit = sampled_q;
      bus.deser_en    = (state_q == DATA) && e_mid;
      bus.data_valid  = data_valid_q;
      bus.par_err     = par_err_q;
      bus.stp_err     = stp_err_q;
      bus.busy        = (state_q != IDLE);
   end
endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: frames driven bit by bit, pulses logged against the start-detect cycle.
module tb_uart_rx_fsm;
   localparam int DATA_W = 8;
   localparam int PW     = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail  = 0;

   int   de_t[$];
   logic de_b[$];
   int   dv_t[$];
   logic dbl = 1'b0, de_prev = 1'b0, dv_prev = 1'b0;

   uart_rx_fsm_if #(.PRESCALE_W(PW)) bus ();

   uart_rx_fsm #(.DATA_W(DATA_W), .PRESCALE_W(PW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.deser_en) begin
         de_t.push_back(cyc);
         de_b.push_back(bus.sampled_bit);
      end
      if (bus.data_valid) dv_t.push_back(cyc);
      if ((bus.deser_en && de_prev) || (bus.data_valid && dv_prev)) dbl <= 1'b1;
      de_prev <= bus.deser_en;
      dv_prev <= bus.data_valid;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [5:0] outs();
      return {bus.sampled_bit, bus.deser_en, bus.data_valid, bus.par_err, bus.stp_err, bus.busy};
   endfunction

   task automatic clear_logs();
      de_t.delete();
      de_b.delete();
      dv_t.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.rx_in = 1'b1;
      end
   endtask

   // gl_at inverts the line for one cycle at that offset; rst_at aborts the frame by asserting rst there.
   task automatic send_frame(input logic [7:0] d, input int p, input logic pe, input logic pt,
                             input logic par, input logic stp, input int gl_at, input int rst_at,
                             output int t0);
      logic [11:0] bits;
      int          nb;
      bits = '1;
      bits[0] = 1'b0;
      for (int k = 0; k < 8; k++) bits[1+k] = d[k];
      nb = 10 + int'(pe);
      if (pe) bits[9] = par;
      bits[nb-1] = stp;
      t0 = 0;
      for (int i = 0; i < nb; i++) begin
         for (int j = 0; j < p; j++) begin
            @(negedge clk);
            if (i == 0 && j == 0) begin
               t0 = cyc;
               bus.prescale = PW'(p);
               bus.par_en   = pe;
               bus.par_typ  = pt;
            end
            if (i == 1 && j == 0) begin
               bus.prescale = PW'(13);
               bus.par_en   = ~pe;
               bus.par_typ  = ~pt;
            end
            if (i * p + j == rst_at) begin
               rst       = 1'b1;
               bus.rx_in = 1'b1;
               return;
            end
            bus.rx_in = (i * p + j == gl_at) ? ~bits[i] : bits[i];
         end
      end
   endtask

   task automatic check_frame(input string tag, input int f, input int t0, input logic [7:0] d,
                              input int p, input int nb, input logic dv_exp);
      logic [7:0] got_d;
      int         bad_t;
      int         idx;
      got_d = '0;
      bad_t = 0;
      for (int k = 0; k < 8; k++) begin
         idx = f * 8 + k;
         if (idx < de_t.size()) begin
            got_d[k] = de_b[idx];
            if (de_t[idx] - t0 != (k + 1) * p + p / 2 + 2) bad_t++;
         end else begin
            bad_t++;
         end
      end
      chk({tag, "_bits"}, 32'(got_d), 32'(d));
      chk({tag, "_de_time_errs"}, bad_t, 0);
      if (dv_exp)
         chk({tag, "_dv_time"}, (dv_t.size() > f) ? dv_t[f] - t0 : -1, nb * p);
   endtask

   initial begin
      int t0, t1;
      bus.rx_in    = 1'b1;
      bus.prescale = PW'(8);
      bus.par_en   = 1'b0;
      bus.par_typ  = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_outs", 32'(outs()), 0);
      rst = 1'b0;
      idle(3);

      clear_logs();
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, t0);
      idle(6);
      chk("A_de_cnt", de_t.size(), 8);
      check_frame("A", 0, t0, 8'hA5, 8, 10, 1'b1);
      chk("A_dv_cnt", dv_t.size(), 1);
      chk("A_errs", {bus.par_err, bus.stp_err}, 0);
      chk("A_busy_idle", bus.busy, 0);

      clear_logs();
      send_frame(8'h0F, 16, 1'b1, 1'b0, 1'b0, 1'b1, -1, -1, t0);
      idle(6);
      check_frame("B", 0, t0, 8'h0F, 16, 11, 1'b1);
      chk("B_par_err", bus.par_err, 0);

      clear_logs();
      send_frame(8'h0F, 16, 1'b1, 1'b0, 1'b1, 1'b1, -1, -1, t0);
      idle(6);
      chk("B2_de_cnt", de_t.size(), 8);
      chk("B2_dv_cnt", dv_t.size(), 0);
      chk("B2_par_err", bus.par_err, 1);

      clear_logs();
      @(negedge clk);
      t0 = cyc;
      bus.rx_in = 1'b0;
      bus.prescale = PW'(8);
      bus.par_en = 1'b0;
      @(negedge clk);
      bus.rx_in = 1'b0;
      chk("G_busy_hi", bus.busy, 1);
      chk("G_flags_cleared", {bus.par_err, bus.stp_err}, 0);
      @(negedge clk);
      bus.rx_in = 1'b0;
      @(negedge clk);
      bus.rx_in = 1'b1;
      while (cyc < t0 + 6) @(negedge clk);
      chk("G_busy_edge6", bus.busy, 1);
      @(negedge clk);
      chk("G_busy_lo_c7", bus.busy, 0);
      idle(4);
      chk("G_de_cnt", de_t.size(), 0);
      chk("G_dv_cnt", dv_t.size(), 0);
      chk("G_flags", {bus.par_err, bus.stp_err}, 0);

      clear_logs();
      send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, t0);
      idle(12);
      check_frame("S", 0, t0, 8'h5A, 8, 10, 1'b0);
      chk("S_stp_err_held", bus.stp_err, 1);
      chk("S_dv_cnt", dv_t.size(), 0);

      clear_logs();
      send_frame(8'h12, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, t0);
      send_frame(8'h34, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, t1);
      idle(6);
      chk("BB_gap", t1 - t0, 80);
      chk("BB_dv_cnt", dv_t.size(), 2);
      check_frame("BB0", 0, t0, 8'h12, 8, 10, 1'b1);
      check_frame("BB1", 1, t1, 8'h34, 8, 10, 1'b1);
      chk("BB_stp_err", bus.stp_err, 0);

      clear_logs();
      send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b1, 4 * 8 + 4, -1, t0);
      idle(6);
      check_frame("M", 0, t0, 8'hFF, 8, 10, 1'b1);

      clear_logs();
      send_frame(8'h99, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 5 * 8 + 3, t0);
      @(negedge clk);
      chk("R_outs", 32'(outs()), 0);
      chk("R_de_cnt", de_t.size(), 4);
      rst = 1'b0;
      bus.rx_in = 1'b1;
      idle(4);
      chk("R_dv_cnt", dv_t.size(), 0);

      clear_logs();
      send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, t0);
      idle(6);
      check_frame("R2", 0, t0, 8'h3C, 8, 10, 1'b1);
      chk("R2_dv_cnt", dv_t.size(), 1);

      chk("no_double_pulse", dbl, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
